// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } arb_state_t;

    typedef enum logic {
        PortI,
        PortD
    } arb_port_t;

    // Fetches are always full-word accesses.
    localparam logic [1:0] SizeWord = 2'b10;

    // Access fields captured at grant time and presented to memory.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } mem_fields_t;

    // Pick a port among the pending ones; on a tie, the port not granted last wins.
    function automatic arb_port_t arb_pick(input logic      i_pend,
                                           input logic      d_pend,
                                           input arb_port_t last_grant);
        if (d_pend && (!i_pend || last_grant == PortI)) begin
            return PortD;
        end
        return PortI;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data
// access requesters, with one access outstanding at a time and round-robin ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,

    input  logic [31:0] imem_addr_i,
    input  logic        imem_rd_en_i,
    output logic [31:0] imem_data_o,
    output logic        imem_stall_o,

    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    input  logic        dmem_rd_en_i,
    input  logic        dmem_wr_en_i,
    input  logic [1:0]  dmem_size_i,
    input  logic        dmem_sign_i,
    output logic [31:0] dmem_data_o,
    output logic        dmem_stall_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [1:0]  mem_size_o,
    output logic        mem_sign_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    arb_state_t  state_q, state_d;
    arb_port_t   last_grant_q, last_grant_d;
    mem_fields_t lat_q, lat_d;
    logic [31:0] imem_hold_q, imem_hold_d;
    logic [31:0] dmem_hold_q, dmem_hold_d;

    logic i_done, d_done, completing, arb_open;
    logic i_pend, d_pend;

    assign i_done     = (state_q == StBusyI) && mem_ack_i;
    assign d_done     = (state_q == StBusyD) && mem_ack_i;
    assign completing = i_done || d_done;
    assign arb_open   = (state_q == StIdle) || completing;

    // A port whose access completes this cycle is no longer pending, so its
    // still-asserted request is not granted a second time.
    assign i_pend = imem_rd_en_i && !i_done;
    assign d_pend = (dmem_rd_en_i || dmem_wr_en_i) && !d_done;

    // Completion bookkeeping and same-edge re-arbitration.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_d        = lat_q;
        imem_hold_d  = imem_hold_q;
        dmem_hold_d  = dmem_hold_q;

        if (i_done) begin
            state_d      = StIdle;
            last_grant_d = PortI;
            imem_hold_d  = mem_rdata_i;
        end else if (d_done) begin
            state_d      = StIdle;
            last_grant_d = PortD;
            if (!lat_q.we) begin
                dmem_hold_d = mem_rdata_i;
            end
        end

        if (arb_open && (i_pend || d_pend)) begin
            if (arb_pick(i_pend, d_pend, last_grant_d) == PortD) begin
                state_d     = StBusyD;
                // Simultaneous read and write enables resolve to a write.
                lat_d.we    = dmem_wr_en_i;
                lat_d.addr  = dmem_addr_i;
                lat_d.wdata = dmem_wr_en_i ? dmem_data_i : 32'h0;
                lat_d.size  = dmem_size_i;
                lat_d.sign  = dmem_sign_i;
            end else begin
                state_d     = StBusyI;
                lat_d.we    = 1'b0;
                lat_d.addr  = imem_addr_i;
                lat_d.wdata = 32'h0;
                lat_d.size  = SizeWord;
                lat_d.sign  = 1'b0;
            end
        end
    end

    // State, grant history, latched access fields and read-data hold registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= PortI;
            lat_q        <= '0;
            imem_hold_q  <= 32'h0;
            dmem_hold_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_q        <= lat_d;
            imem_hold_q  <= imem_hold_d;
            dmem_hold_q  <= dmem_hold_d;
        end
    end

    assign mem_req_o   = (state_q != StIdle);
    assign mem_we_o    = (state_q == StBusyD) && lat_q.we;
    assign mem_addr_o  = lat_q.addr;
    assign mem_wdata_o = lat_q.wdata;
    assign mem_size_o  = lat_q.size;
    assign mem_sign_o  = lat_q.sign;

    // Stalls drop combinationally in the completion cycle.
    assign imem_stall_o = i_pend;
    assign dmem_stall_o = d_pend;

    assign imem_data_o = i_done ? mem_rdata_i : imem_hold_q;
    assign dmem_data_o = d_done ? mem_rdata_i : dmem_hold_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  core clock; all state changes on rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 imem_addr_i  in  32  fetch address; imem_rd_en_i  in  1  fetch request.
REQ-005 imem_data_o  out  32  fetch data; imem_stall_o  out  1  fetch not yet complete.
REQ-006 dmem_addr_i  in  32; dmem_data_i  in  32  store data; dmem_rd_en_i  in  1; dmem_wr_en_i  in  1.
REQ-007 dmem_size_i  in  2  byte/half/word; dmem_sign_i  in  1  signed load.
REQ-008 dmem_data_o  out  32  load data; dmem_stall_o  out  1  data access not yet complete.
REQ-009 mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32; mem_size_o  out  2; mem_sign_o  out  1.
REQ-010 mem_ack_i  in  1  access done this cycle; mem_rdata_i  in  32  read data, valid when mem_ack_i=1.

Function
REQ-011 SHALL share one single-port unified memory between IMEM and DMEM requesters, one outstanding access at a time.
REQ-012 FSM states SHALL be IDLE, BUSY_I, BUSY_D.
REQ-013 IDLE: only imem request -> BUSY_I; only dmem request (rd or wr) -> BUSY_D; none -> stay IDLE.
REQ-014 Both pending at arbitration: grant port not granted last (last_grant flag); last_grant resets to IMEM, so first tie goes to DMEM.
REQ-015 On grant, request fields SHALL be latched; mem_req_o and mem_* outputs driven from latched fields, held stable until mem_ack_i.
REQ-016 mem_req_o=1 exactly in BUSY_I/BUSY_D; mem_we_o=1 only in BUSY_D for a write.
REQ-017 dmem_rd_en_i and dmem_wr_en_i both high SHALL be treated as write.
REQ-018 BUSY_x with mem_ack_i=1: complete access; rdata captured into that port's hold register on reads; update last_grant; next state per REQ-013/014 evaluated on same edge (back-to-back, no IDLE bubble).
REQ-019 BUSY_x with mem_ack_i=0: stay; mem_ack_i in IDLE SHALL be ignored.
REQ-020 Minimum access latency: request seen cycle N, mem_req_o cycle N+1, earliest completion cycle N+1.
REQ-021 x_stall_o = x request asserted AND NOT (state==BUSY_x AND mem_ack_i) -- deasserts combinationally in completion cycle.
REQ-022 x_data_o = mem_rdata_i in the completion cycle of that port, else that port's hold register.
REQ-023 Requesters SHALL hold request stable while stalled; arbiter latches at grant and does not track later changes.
REQ-024 Write completion SHALL not modify dmem hold register.
REQ-025 Request dropped while not yet granted: no access issued.

Reset
REQ-026 rst_i=1: state IDLE, last_grant IMEM, latched fields and hold registers 0; overrides mem_ack_i.
REQ-027 During/after reset until a grant: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_size_o=0, mem_sign_o=0, imem_data_o=0, dmem_data_o=0.
REQ-028 Reset mid-access SHALL abandon the access; stall outputs follow REQ-021 with state IDLE.

Structure
REQ-029 Shared package (util.sv) SHALL hold arb_state_t (IDLE, BUSY_I, BUSY_D) and arb_port_t (PORT_I, PORT_D).
REQ-030 Single flat module; no sub-module needed.

Verification
REQ-031 Fetch 0x100, ack one cycle later with rdata 0xDEADBEEF -> mem_addr_o=0x100, imem_stall_o high 1 cycle, imem_data_o=0xDEADBEEF held.
REQ-032 Simultaneous fetch 0x200 and load 0x400 after reset -> DMEM served first, then IMEM back-to-back; dmem_stall_o drops first.
REQ-033 Two consecutive ties -> grants alternate D,I,D,I.
REQ-034 Store 0x55 to 0x10, size 2'b00, ack delayed 3 cycles -> mem_we_o=1, mem_wdata_o=0x55 stable 4 cycles; dmem_data_o unchanged.
REQ-035 rst_i mid BUSY_D, ack in same cycle -> next cycle IDLE, mem_req_o=0, hold register 0.
REQ-036 mem_ack_i pulsed in IDLE -> no output or state change.
